// File: rtl/instr_encoder.sv
// instr_encoder: turns a request (op_sel plus register/immediate fields) into a
// 32-bit LEGv8 instruction word and queues it in a 2-entry output FIFO.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   req_valid/ready request handshake (req_ready is registered and does not
//                   depend on instr_ready)
//   op_sel          0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 reserved
//   rd, rn, rm      register fields (rd also carries Rt for LDUR/STUR/CBZ)
//   imm             signed immediate; D-format uses imm[8:0], CBZ uses imm[18:0]
//   instruction     oldest buffered word (32'h0 after reset)
//   instr_valid     instruction is valid
//   instr_ready     consumer accepts instruction
//   enc_err         one-cycle pulse after a rejected request
//   instr_count     number of words pushed into the FIFO (wrapping)
//
// Configuration
//   ENC_CHECK_EN    when defined, reserved opcodes and D-format immediates
//                   that do not fit a 9-bit signed field are rejected. When
//                   undefined, op_sel=7 encodes ADD X31,X31,X31, D-format
//                   immediates are truncated and enc_err stays 0.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        enc_err,
  output logic [15:0] instr_count
);

  localparam int unsigned W_INSTR = 32;
  localparam int unsigned W_CNT   = 16;
  localparam int unsigned W_OPC   = 11;

  localparam logic [W_OPC-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [W_OPC-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [W_OPC-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [W_OPC-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [W_OPC-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [W_OPC-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]       OPC_CBZ  = 8'b10110100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [W_INSTR-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [W_INSTR-1:0] word_c;
  logic               reject_c;
  logic               accept_c;
  logic               push_c;
  logic               pop_c;

  // Combinational field packing of the current request.
  always_comb begin
    word_c   = '0;
    reject_c = 1'b0;
    unique case (op_sel)
      3'd0: word_c = {OPC_ADD,  rm, 6'b0, rn, rd};
      3'd1: word_c = {OPC_SUB,  rm, 6'b0, rn, rd};
      3'd2: word_c = {OPC_AND,  rm, 6'b0, rn, rd};
      3'd3: word_c = {OPC_ORR,  rm, 6'b0, rn, rd};
      3'd4: word_c = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      3'd5: word_c = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      3'd6: word_c = {OPC_CBZ,  imm, rd};
      default: begin
`ifdef ENC_CHECK_EN
        reject_c = 1'b1;
`else
        word_c = {OPC_ADD, 5'd31, 6'b0, 5'd31, 5'd31};
`endif
      end
    endcase
`ifdef ENC_CHECK_EN
    // D-format offset must sign-extend cleanly from bit 8.
    if ((op_sel == 3'd4 || op_sel == 3'd5) && (imm[18:8] != {11{imm[8]}}))
      reject_c = 1'b1;
`endif
  end

  assign accept_c = req_valid && req_ready;
  assign push_c   = accept_c && !reject_c;
  assign pop_c    = instr_valid && instr_ready;

  // FIFO occupancy next-state.
  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (push_c) state_n = ONE;
      ONE: begin
        if (push_c && !pop_c)      state_n = FULL;
        else if (pop_c && !push_c) state_n = EMPTY;
      end
      FULL:  if (pop_c) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  // Storage, pointers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      req_ready   <= 1'b0;
      instr_valid <= 1'b0;
      enc_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= word_c;
        wr_ptr      <= ~wr_ptr;
        instr_count <= instr_count + W_CNT'(1);
      end
      if (pop_c) rd_ptr <= ~rd_ptr;
      req_ready   <= (state_n != FULL);
      instr_valid <= (state_n != EMPTY);
      enc_err     <= accept_c && reject_c;
    end
  end

  assign instruction = mem[rd_ptr];

endmodule
